// File: rtl/aclock_pkg.sv
// Shared types, limits and BCD arithmetic for the aclock front-panel setter.
package aclock_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT_H = 2'd1,
    S_EDIT_M = 2'd2,
    S_COMMIT = 2'd3
  } setter_state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  localparam logic [1:0] HOUR_MAX_H1      = 2'd2;
  localparam logic [3:0] HOUR_MAX_H0_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_M1       = 4'd5;

  // Hours wrap 23 -> 00; minutes are left untouched.
  function automatic bcd_time_t bcd_inc_hour(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.h1 == HOUR_MAX_H1 && t.h0 == HOUR_MAX_H0_AT_2) begin
      r.h1 = '0;
      r.h0 = '0;
    end else if (t.h0 == 4'd9) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = '0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes wrap 59 -> 00 without carrying into the hour digits.
  function automatic bcd_time_t bcd_inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.m0 == 4'd9) begin
      r.m0 = '0;
      r.m1 = (t.m1 == MIN_MAX_M1) ? 4'd0 : t.m1 + 4'd1;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_btn;
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/aclock_setter.sv
// Button-driven hour/minute editor that loads the aclock time or alarm registers.
module aclock_setter
  import aclock_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic       sel_alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       edit_hr,
  output logic       edit_min
);

  localparam int unsigned CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] REP_LAST = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic w_mode_rise, w_inc_rise, w_cancel_rise;

  btn_edge u_mode   (.i_clk(clk), .i_rst(reset), .i_btn(btn_mode),   .o_rise(w_mode_rise));
  btn_edge u_inc    (.i_clk(clk), .i_rst(reset), .i_btn(btn_inc),    .o_rise(w_inc_rise));
  btn_edge u_cancel (.i_clk(clk), .i_rst(reset), .i_btn(btn_cancel), .o_rise(w_cancel_rise));

  setter_state_t r_state, w_state_nx;
  logic          r_target, w_target_nx;
  bcd_time_t     r_work, w_work_nx;
  bcd_time_t     r_commit, w_commit_nx;
  bcd_time_t     r_shadow, w_shadow_nx;
  logic [CW-1:0] r_rep, w_rep_nx;
  logic          w_rep_tick;
  logic          w_in_edit;

  bcd_time_t     r_disp;
  logic          r_ld_time, r_ld_alarm, r_edit_hr, r_edit_min;

  assign w_in_edit  = (r_state == S_EDIT_H) || (r_state == S_EDIT_M);
  assign w_rep_tick = (REPEAT_CYCLES != 0) && btn_inc && !w_inc_rise && (r_rep == REP_LAST);

  always_comb begin
    w_state_nx  = r_state;
    w_target_nx = r_target;
    w_work_nx   = r_work;
    w_commit_nx = r_commit;
    w_shadow_nx = r_shadow;
    unique case (r_state)
      S_IDLE: begin
        if (w_mode_rise) begin
          w_state_nx  = S_EDIT_H;
          w_target_nx = sel_alarm;
          w_work_nx   = sel_alarm ? r_shadow : {cur_H1, cur_H0, cur_M1, cur_M0};
        end
      end
      S_EDIT_H, S_EDIT_M: begin
        if (w_cancel_rise) begin
          w_state_nx = S_IDLE;
        end else if (w_mode_rise) begin
          if (r_state == S_EDIT_H) begin
            w_state_nx = S_EDIT_M;
          end else begin
            // Committed/shadow update on entry to COMMIT so outputs show the value during the strobe.
            w_state_nx  = S_COMMIT;
            w_commit_nx = r_work;
            if (r_target) w_shadow_nx = r_work;
          end
        end else if (w_inc_rise || w_rep_tick) begin
          w_work_nx = (r_state == S_EDIT_H) ? bcd_inc_hour(r_work) : bcd_inc_min(r_work);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rep_nx = r_rep + CW'(1);
    if (!w_in_edit || w_state_nx != r_state || w_inc_rise || !btn_inc || r_rep == REP_LAST)
      w_rep_nx = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_target   <= 1'b0;
      r_work     <= '0;
      r_commit   <= '0;
      r_shadow   <= '0;
      r_rep      <= '0;
      r_disp     <= '0;
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_edit_hr  <= 1'b0;
      r_edit_min <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_target   <= w_target_nx;
      r_work     <= w_work_nx;
      r_commit   <= w_commit_nx;
      r_shadow   <= w_shadow_nx;
      r_rep      <= w_rep_nx;
      r_disp     <= (w_state_nx == S_EDIT_H || w_state_nx == S_EDIT_M) ? w_work_nx : w_commit_nx;
      r_ld_time  <= (w_state_nx == S_COMMIT) && !w_target_nx;
      r_ld_alarm <= (w_state_nx == S_COMMIT) && w_target_nx;
      r_edit_hr  <= (w_state_nx == S_EDIT_H);
      r_edit_min <= (w_state_nx == S_EDIT_M);
    end
  end

  assign H_in1    = r_disp.h1;
  assign H_in0    = r_disp.h0;
  assign M_in1    = r_disp.m1;
  assign M_in0    = r_disp.m0;
  assign LD_time  = r_ld_time;
  assign LD_alarm = r_ld_alarm;
  assign edit_hr  = r_edit_hr;
  assign edit_min = r_edit_min;

endmodule

// File: tb/tb_aclock_setter.sv
// Scoreboard bench for aclock_setter against an integer hour/minute reference model.
module tb_aclock_setter;

  localparam int RC = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0, sel_alarm = 1'b0;
  logic [1:0] cur_H1, H_in1;
  logic [3:0] cur_H0, cur_M1, cur_M0, H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, edit_hr, edit_min;
  int         cur_h = 0, cur_m = 0;

  assign cur_H1 = 2'(cur_h / 10);
  assign cur_H0 = 4'(cur_h % 10);
  assign cur_M1 = 4'(cur_m / 10);
  assign cur_M0 = 4'(cur_m % 10);

  aclock_setter #(.REPEAT_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_cancel(btn_cancel), .sel_alarm(sel_alarm),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .edit_hr(edit_hr), .edit_min(edit_min)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] disp;
    logic        ld_t;
    logic        ld_a;
    logic        eh;
    logic        em;
  } obs_t;

  obs_t  exp_q[$];
  string lbl_q[$];
  int    checks = 0, errors = 0;

  // Reference model: phase 0 idle, 1 hours, 2 minutes, 3 commit; times as plain integers.
  int ph, tgt, wh, wm, ch, cm, sh, sm, age;
  bit pm, pi, pc;

  function automatic logic [13:0] to_bcd(input int h, input int m);
    logic [13:0] v;
    v = {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    return v;
  endfunction

  task automatic model_reset();
    ph = 0; tgt = 0; wh = 0; wm = 0; ch = 0; cm = 0; sh = 0; sm = 0; age = 0;
    pm = 0; pi = 0; pc = 0;
  endtask

  task automatic model_step(input bit m, input bit i, input bit c, input bit s);
    bit rm, ri, rc, bump;
    int old;
    rm = m && !pm; ri = i && !pi; rc = c && !pc;
    pm = m; pi = i; pc = c;
    old = ph; bump = 0;
    if ((ph == 1 || ph == 2) && i && !ri) begin
      age++;
      bump = (age % RC) == 0;
    end else begin
      age = 0;
    end
    case (ph)
      0: if (rm) begin
        ph = 1; tgt = s;
        if (s) begin wh = sh; wm = sm; end
        else   begin wh = cur_h; wm = cur_m; end
      end
      1, 2: begin
        if (rc) ph = 0;
        else if (rm) begin
          if (ph == 1) ph = 2;
          else begin
            ph = 3; ch = wh; cm = wm;
            if (tgt != 0) begin sh = wh; sm = wm; end
          end
        end else if (ri || bump) begin
          if (ph == 1) wh = (wh + 1) % 24;
          else         wm = (wm + 1) % 60;
        end
      end
      default: ph = 0;
    endcase
    if (ph != old) age = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.disp = (ph == 1 || ph == 2) ? to_bcd(wh, wm) : to_bcd(ch, cm);
    o.ld_t = (ph == 3) && (tgt == 0);
    o.ld_a = (ph == 3) && (tgt != 0);
    o.eh   = (ph == 1);
    o.em   = (ph == 2);
    return o;
  endfunction

  task automatic step_r(input bit r, input bit m, input bit i, input bit c, input bit s, input string l);
    @(negedge clk);
    reset = r; btn_mode = m; btn_inc = i; btn_cancel = c; sel_alarm = s;
    if (r) model_reset();
    else   model_step(m, i, c, s);
    exp_q.push_back(model_obs());
    lbl_q.push_back(l);
  endtask

  task automatic step(input bit m, input bit i, input bit c, input bit s, input string l);
    step_r(0, m, i, c, s, l);
  endtask

  task automatic press(input bit m, input bit i, input bit c, input bit s, input string l);
    step(m, i, c, s, l);
    step(0, 0, 0, s, l);
  endtask

  task automatic incs(input int n, input bit s, input string l);
    for (int k = 0; k < n; k++) press(0, 1, 0, s, l);
  endtask

  initial begin : monitor
    obs_t  e, g;
    string l;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        g = {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_hr, edit_min};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s: got time=%h ld_t=%b ld_a=%b eh=%b em=%b, expected time=%h ld_t=%b ld_a=%b eh=%b em=%b",
                   l, g.disp, g.ld_t, g.ld_a, g.eh, g.em, e.disp, e.ld_t, e.ld_a, e.eh, e.em);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    step_r(1, 0, 0, 0, 0, "reset");
    step_r(1, 0, 0, 0, 0, "reset");

    cur_h = 10; cur_m = 14;
    press(1, 0, 0, 0, "time_enter");
    cur_h = 5; cur_m = 55;
    incs(3, 0, "time_hours");
    press(1, 0, 0, 0, "time_to_min");
    press(1, 0, 0, 0, "time_commit");
    step(0, 0, 0, 0, "time_after");

    press(1, 0, 0, 1, "alarm_enter");
    incs(11, 1, "alarm_hours");
    press(1, 0, 0, 1, "alarm_to_min");
    incs(30, 1, "alarm_mins");
    press(1, 0, 0, 1, "alarm_commit");
    press(1, 0, 0, 1, "alarm_reenter");
    press(0, 0, 1, 1, "alarm_cancel");

    cur_h = 23; cur_m = 59;
    press(1, 0, 0, 0, "wrap_enter");
    incs(1, 0, "wrap_h23");
    press(1, 0, 0, 0, "wrap_to_min");
    incs(1, 0, "wrap_m59");
    press(0, 0, 1, 0, "wrap_cancel");
    cur_h = 9; cur_m = 9;
    press(1, 0, 0, 0, "wrap_enter9");
    incs(1, 0, "wrap_h09");
    press(1, 0, 0, 0, "wrap_to_min9");
    incs(1, 0, "wrap_m09");
    press(0, 0, 1, 0, "wrap_cancel9");
    cur_h = 19; cur_m = 0;
    press(1, 0, 0, 0, "wrap_enter19");
    incs(1, 0, "wrap_h19");
    press(0, 0, 1, 0, "wrap_cancel19");

    cur_h = 12; cur_m = 0;
    press(1, 0, 0, 0, "hold_enter");
    press(1, 0, 0, 0, "hold_to_min");
    for (int k = 0; k < 16; k++) step(0, 1, 0, 0, "hold_repeat");
    step(0, 0, 0, 0, "hold_release");
    press(1, 0, 0, 0, "hold_commit");

    cur_h = 7; cur_m = 30;
    press(1, 0, 0, 0, "cancel_enter");
    incs(2, 0, "cancel_hours");
    press(1, 0, 0, 0, "cancel_to_min");
    incs(2, 0, "cancel_mins");
    press(0, 0, 1, 0, "cancel_revert");
    press(1, 0, 0, 0, "both_enter");
    press(1, 0, 0, 0, "both_to_min");
    press(1, 0, 1, 0, "both_cancel_wins");
    step(0, 0, 0, 0, "both_after");

    press(1, 0, 0, 0, "rst_enter");
    press(1, 0, 0, 0, "rst_to_min");
    incs(2, 0, "rst_mins");
    step_r(1, 0, 0, 0, 0, "rst_mid_edit");
    step_r(1, 1, 0, 0, 0, "rst_hold_mode");
    step_r(0, 1, 0, 0, 0, "rst_release_rise");
    step(0, 0, 0, 0, "rst_after");
    press(0, 0, 1, 0, "rst_cancel");

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 30) == 0) begin
        cur_h = $urandom_range(0, 23);
        cur_m = $urandom_range(0, 59);
      end
      step($urandom_range(0, 6) == 0,
           (btn_inc && $urandom_range(0, 9) != 0) || $urandom_range(0, 3) == 0,
           $urandom_range(0, 25) == 0,
           1'($urandom_range(0, 1)), "random");
    end
    step(0, 0, 0, 0, "drain");
    step(0, 0, 0, 0, "drain");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclock_setter.md
# aclock_setter

Button-driven time/alarm entry controller that feeds the load interface of the `aclock` alarm-clock core. It turns debounced mode/increment/cancel buttons into a BCD hour/minute edit sequence. On commit it presents the edited value on `H_in1/H_in0/M_in1/M_in0` and issues a single-cycle `LD_time` or `LD_alarm` strobe. It sits between the front-panel button logic and `aclock`, replacing direct stimulus of the load ports.

## Interface
- `REPEAT_CYCLES`, default 5: number of `clk` cycles per auto-repeat step while `btn_inc` is held (0.5 s at 10 Hz).
- `clk` in 1: system clock, 10 Hz nominal.
- `reset` in 1: asynchronous, active-high reset.
- `btn_mode` in 1: debounced level, synchronous to `clk`. A rising edge enters or advances edit.
- `btn_inc` in 1: debounced level. A rising edge increments the current field; holding it auto-repeats.
- `btn_cancel` in 1: debounced level. A rising edge aborts the edit with no load.
- `sel_alarm` in 1: edit target, 0 = clock time, 1 = alarm time. Sampled only on edit entry.
- `cur_H1` in 2, `cur_H0` in 4, `cur_M1` in 4, `cur_M0` in 4: current clock time from `aclock` outputs, BCD.
- `H_in1` out 2, `H_in0` out 4, `M_in1` out 4, `M_in0` out 4: value presented to `aclock` load inputs, BCD.
- `LD_time` out 1: single-cycle strobe that loads the clock time.
- `LD_alarm` out 1: single-cycle strobe that loads the alarm time.
- `edit_hr` out 1: hour field is being edited.
- `edit_min` out 1: minute field is being edited.

## Operation
- **Edge detection**
  - Each button has a registered previous value; rise = `btn & ~prev`.
  - `prev` registers reset to 0, so a button held high through reset release counts as a rise on the first edge.
- **States:** IDLE, EDIT_H, EDIT_M, COMMIT.
- **IDLE**
  - `btn_mode` rise → EDIT_H.
  - Latch target = `sel_alarm`.
  - Load the working register from `cur_*` (target 0) or from the alarm shadow (target 1).
- **EDIT_H**
  - `btn_inc` rise or repeat → hours +1 in BCD: 09→10, 19→20, 23→00.
  - `btn_mode` rise → EDIT_M.
- **EDIT_M**
  - `btn_inc` rise or repeat → minutes +1 in BCD: 09→10, 59→00.
  - No carry into hours.
  - `btn_mode` rise → COMMIT.
- **COMMIT**
  - Exactly one cycle.
  - Committed register ← working register.
  - If target = 1, alarm shadow ← working register.
  - Strobe `LD_time` (target 0) or `LD_alarm` (target 1); then → IDLE.
- **Cancel:** `btn_cancel` rise in EDIT_H or EDIT_M → IDLE. Working value is discarded; no strobe.
- **Event priority within one cycle:** cancel > mode > inc. An inc coinciding with mode is dropped.
- **Outputs**
  - `H_in*/M_in*` show the working register during EDIT_H/EDIT_M.
  - They show the committed register in IDLE and COMMIT.
  - `edit_hr` = (state == EDIT_H); `edit_min` = (state == EDIT_M).
- **Auto-repeat**
  - The counter clears on an `btn_inc` rise, on release, and on any state change.
  - While `btn_inc` stays high in an edit state, an increment fires every `REPEAT_CYCLES` cycles after the rise.
- **Reset:** state IDLE, working = committed = alarm shadow = 00:00, all outputs 0, repeat counter 0.

## Timing
- All outputs are registered.
- A button rise sampled at edge k takes effect, and is visible on outputs, after edge k.
- Commit latency: the `btn_mode` rise in EDIT_M sampled at edge k puts the strobe high for cycle k..k+1 only.
  - `H_in*/M_in*` already equal the committed value in that cycle and hold it afterwards.
- Inputs are never read in COMMIT; a button rise during COMMIT is lost.
- Reset asserted mid-edit or mid-COMMIT aborts immediately; no strobe is emitted.
- `cur_*` is sampled once, on the IDLE→EDIT_H edge. Later changes do not affect the working value.

## Structure
- Package `aclock_pkg`:
  - state enum `setter_state_t`;
  - BCD time struct `{h1[1:0], h0[3:0], m1[3:0], m0[3:0]}`;
  - constants `HOUR_MAX_H1 = 2`, `HOUR_MAX_H0_AT_2 = 3`, `MIN_MAX_M1 = 5`.
- One sub-module `btn_edge`, instantiated three times: registered prev plus rise output.
- BCD increment functions live in the package.

## Test plan
- Reset, then mode, inc×3, mode, mode with `sel_alarm=0` and `cur`=10:14 → one-cycle `LD_time`; outputs 13:14; `LD_alarm` stays 0.
- `sel_alarm=1`, edit hours from shadow 00:00 by 11 incs, minutes by 30 incs, then commit → `LD_alarm` pulse; outputs 11:30; re-entry with `sel_alarm=1` starts at 11:30.
- Wrap: hours 23 + inc → 00; minutes 59 + inc → 00 with hours unchanged; 09→10 and 19→20 checked.
- Hold `btn_inc` for 16 cycles in EDIT_M from minute 00 → 04 (rise plus 3 repeats at cycles 5, 10, 15).
- Cancel in EDIT_M after changes → no strobe; outputs revert to prior committed value. Cancel and mode in the same cycle → cancel wins.
- Reset asserted in EDIT_M → outputs 00:00, no `LD_*`; a button held through reset release enters EDIT_H on the first edge.
